// File: rtl/riscv_i32_debug_fetch_ctrl_pkg.sv
// Shared riscv fetch/debug types plus debug-fetch controller state and constants.
package riscv_i32_debug_fetch_ctrl_pkg;

  // Debugger command / result channel.
  typedef struct packed {
    logic        valid;
    logic        halt_request;
    logic        fetch_dret;
    logic        kill_fetch;
    logic [31:0] data;
  } t_riscv_debug_control;

  typedef struct packed {
    logic        flush_pipeline;
    logic [1:0]  req_type;
    logic [31:0] address;
  } t_riscv_fetch_req;

  typedef struct packed {
    logic        valid;
    logic        debug;
    logic [2:0]  mode;
    logic        error;
    logic [1:0]  tag;
    logic [31:0] data;
  } t_riscv_fetch_resp;

  typedef struct packed {
    logic valid;
  } t_riscv_instr_debug;

  typedef struct packed {
    t_riscv_instr_debug debug;
    logic [31:0]        bits;
  } t_riscv_i32_instr;

  typedef struct packed {
    logic             instr_valid;
    logic             trap;
    logic             rfw_data_valid;
    logic [31:0]      rfw_data;
    t_riscv_i32_instr instruction;
  } t_riscv_i32_trace;

  typedef enum logic [2:0] {
    DBG_RUNNING,
    DBG_DRAINING,
    DBG_HALTED,
    DBG_INJECT,
    DBG_WAIT_RETIRE,
    DBG_RESUME
  } t_dbg_state;

  // Mode reported on an injected fetch response (debug/machine mode).
  localparam logic [2:0] DBG_INJECT_MODE   = 3'h3;
  localparam logic [7:0] DBG_TIMEOUT_LIMIT = 8'd255;

endpackage

// File: rtl/riscv_fetch_outstanding_counter.sv
// Saturating 2-bit count of memory fetches still awaiting a response.
module riscv_fetch_outstanding_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       dec,
  output logic [1:0] count
);

  // Up on issue, down on response; simultaneous events cancel; clamp at 0 and 3.
  always_ff @(posedge clk) begin
    if (reset)                            count <= 2'd0;
    else if (inc && !dec && count != 2'd3) count <= count + 2'd1;
    else if (dec && !inc && count != 2'd0) count <= count - 2'd1;
  end

endmodule

// File: rtl/riscv_i32_debug_fetch_ctrl.sv
// Debug fetch controller: halts fetch, injects debugger instructions into the
// pipeline, reports their retirement, and resumes with a pipeline flush.
// Optional: RISCV_DEBUG_FETCH_TIMEOUT_EN adds a 255-cycle inject/retire watchdog.
module riscv_i32_debug_fetch_ctrl
  import riscv_i32_debug_fetch_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  t_riscv_debug_control debug_control,
  output t_riscv_debug_control debug_response,
  input  t_riscv_fetch_req     pipeline_ifetch_req,
  output t_riscv_fetch_req     ifetch_req,
  input  t_riscv_fetch_resp    ifetch_resp,
  output t_riscv_fetch_resp    pipeline_ifetch_resp,
  input  t_riscv_i32_trace     pipeline_trace,
  output logic                 halted
);

  t_dbg_state           state, state_nxt;
  t_riscv_debug_control rsp_nxt;
  logic [31:0]          instr_q;
  logic [1:0]           outstanding;
  logic                 halt_cmd, dret_cmd, inject_cmd, retire, drained;
  logic                 unused_bits;

  // Halt wins when halt_request and fetch_dret arrive together.
  assign halt_cmd   = debug_control.valid &  debug_control.halt_request;
  assign dret_cmd   = debug_control.valid & ~debug_control.halt_request &  debug_control.fetch_dret;
  assign inject_cmd = debug_control.valid & ~debug_control.halt_request & ~debug_control.fetch_dret;
  assign retire     = pipeline_trace.instr_valid & pipeline_trace.instruction.debug.valid;
  // Drained once the last outstanding response is arriving this cycle (or none left).
  assign drained    = (outstanding == 2'd0) || (outstanding == 2'd1 && ifetch_resp.valid);
  assign halted     = (state == DBG_HALTED) || (state == DBG_INJECT) || (state == DBG_WAIT_RETIRE);
  assign unused_bits = ^{pipeline_trace.instruction.bits, debug_control.kill_fetch};

  riscv_fetch_outstanding_counter u_outstanding (
    .clk   (clk),
    .reset (reset),
    .inc   (ifetch_req.req_type != 2'b00),
    .dec   (ifetch_resp.valid),
    .count (outstanding)
  );

`ifdef RISCV_DEBUG_FETCH_TIMEOUT_EN
  logic [7:0] tmo_q;
  logic       tmo_hit;
  assign tmo_hit = (tmo_q == DBG_TIMEOUT_LIMIT);

  // Watchdog sits at 0 while halted so every INJECT entry starts from zero.
  always_ff @(posedge clk) begin
    if (reset || state == DBG_HALTED)                        tmo_q <= 8'd0;
    else if (state == DBG_INJECT || state == DBG_WAIT_RETIRE) tmo_q <= tmo_q + 8'd1;
  end
`endif

  // Next-state, fetch muxing and next debug response.
  always_comb begin
    state_nxt            = state;
    ifetch_req           = '0;
    pipeline_ifetch_resp = '0;
    rsp_nxt              = '0;
    case (state)
      DBG_RUNNING: begin
        ifetch_req           = pipeline_ifetch_req;
        pipeline_ifetch_resp = ifetch_resp;
        if (halt_cmd) state_nxt = DBG_DRAINING;
      end
      DBG_DRAINING: begin
        ifetch_req           = pipeline_ifetch_req;
        ifetch_req.req_type  = 2'b00;
        pipeline_ifetch_resp = ifetch_resp;
        if (drained) state_nxt = DBG_HALTED;
      end
      DBG_HALTED: begin
        if (dret_cmd)        state_nxt = DBG_RESUME;
        else if (inject_cmd) state_nxt = DBG_INJECT;
      end
      DBG_INJECT: begin
        if (pipeline_ifetch_req.req_type != 2'b00) begin
          pipeline_ifetch_resp.valid = 1'b1;
          pipeline_ifetch_resp.debug = 1'b1;
          pipeline_ifetch_resp.mode  = DBG_INJECT_MODE;
          pipeline_ifetch_resp.data  = instr_q;
          state_nxt                  = DBG_WAIT_RETIRE;
        end
`ifdef RISCV_DEBUG_FETCH_TIMEOUT_EN
        else if (tmo_hit) begin
          rsp_nxt.valid      = 1'b1;
          rsp_nxt.kill_fetch = 1'b1;
          rsp_nxt.data       = 32'hFFFF_FFFF;
          state_nxt          = DBG_HALTED;
        end
`endif
      end
      DBG_WAIT_RETIRE: begin
        if (retire) begin
          rsp_nxt.valid      = 1'b1;
          rsp_nxt.kill_fetch = pipeline_trace.trap;
          rsp_nxt.data       = pipeline_trace.rfw_data_valid ? pipeline_trace.rfw_data : 32'd0;
          state_nxt          = DBG_HALTED;
        end
`ifdef RISCV_DEBUG_FETCH_TIMEOUT_EN
        else if (tmo_hit) begin
          rsp_nxt.valid      = 1'b1;
          rsp_nxt.kill_fetch = 1'b1;
          rsp_nxt.data       = 32'hFFFF_FFFF;
          state_nxt          = DBG_HALTED;
        end
`endif
      end
      DBG_RESUME: begin
        ifetch_req                = pipeline_ifetch_req;
        ifetch_req.flush_pipeline = 1'b1;
        pipeline_ifetch_resp      = ifetch_resp;
        state_nxt                 = DBG_RUNNING;
      end
      default: state_nxt = DBG_RUNNING;
    endcase
  end

  // State, captured instruction and registered one-cycle debug response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= DBG_RUNNING;
      instr_q        <= 32'd0;
      debug_response <= '0;
    end else begin
      state          <= state_nxt;
      debug_response <= rsp_nxt;
      if (state == DBG_HALTED && inject_cmd) instr_q <= debug_control.data;
    end
  end

endmodule

// File: tb/tb_riscv_i32_debug_fetch_ctrl.sv
// Scoreboard bench for riscv_i32_debug_fetch_ctrl.
module tb_riscv_i32_debug_fetch_ctrl;
  import riscv_i32_debug_fetch_ctrl_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset;
  t_riscv_debug_control debug_control, debug_response;
  t_riscv_fetch_req     pipeline_ifetch_req, ifetch_req;
  t_riscv_fetch_resp    ifetch_resp, pipeline_ifetch_resp;
  t_riscv_i32_trace     pipeline_trace;
  logic                 halted;

  int n_tests = 0;
  int n_fail  = 0;
  int dbg_seen = 0;

  t_riscv_debug_control exp_dbg[$];
  t_riscv_fetch_resp    exp_resp[$];

  always #5 clk = ~clk;

  riscv_i32_debug_fetch_ctrl dut (
    .clk                  (clk),
    .reset                (reset),
    .debug_control        (debug_control),
    .debug_response       (debug_response),
    .pipeline_ifetch_req  (pipeline_ifetch_req),
    .ifetch_req           (ifetch_req),
    .ifetch_resp          (ifetch_resp),
    .pipeline_ifetch_resp (pipeline_ifetch_resp),
    .pipeline_trace       (pipeline_trace),
    .halted               (halted)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic t_riscv_fetch_req mk_req(input logic [1:0] rt, input logic [31:0] a);
    t_riscv_fetch_req r;
    r = '0; r.req_type = rt; r.address = a;
    return r;
  endfunction

  function automatic t_riscv_fetch_resp mk_resp(input logic [31:0] d, input logic [1:0] tg);
    t_riscv_fetch_resp r;
    r = '0; r.valid = 1'b1; r.tag = tg; r.data = d;
    return r;
  endfunction

  function automatic t_riscv_debug_control mk_dbg(input logic k, input logic [31:0] d);
    t_riscv_debug_control r;
    r = '0; r.valid = 1'b1; r.kill_fetch = k; r.data = d;
    return r;
  endfunction

  function automatic t_riscv_debug_control mk_cmd(input logic h, input logic dr, input logic [31:0] d);
    t_riscv_debug_control r;
    r = '0; r.valid = 1'b1; r.halt_request = h; r.fetch_dret = dr; r.data = d;
    return r;
  endfunction

  // Debug response monitor: every valid beat must match the next scoreboard entry.
  always @(negedge clk) begin
    if (debug_response.valid) begin
      dbg_seen++;
      if (exp_dbg.size() == 0) chk("dbg_rsp_unexpected", 64'(debug_response), 64'd0);
      else chk("dbg_rsp", 64'(debug_response), 64'(exp_dbg.pop_front()));
    end else if (debug_response != '0) begin
      chk("dbg_rsp_idle", 64'(debug_response), 64'd0);
    end
  end

  // Pipeline fetch-response monitor.
  always @(negedge clk) begin
    if (pipeline_ifetch_resp.valid) begin
      if (exp_resp.size() == 0) chk("pl_resp_unexpected", 64'(pipeline_ifetch_resp), 64'd0);
      else chk("pl_resp", 64'(pipeline_ifetch_resp), 64'(exp_resp.pop_front()));
    end
  end

  task automatic send_req(input logic [31:0] a, input logic passes);
    pipeline_ifetch_req = mk_req(2'b01, a);
    @(negedge clk);
    chk("req_type", 64'(ifetch_req.req_type), passes ? 64'd1 : 64'd0);
    tick();
    pipeline_ifetch_req = '0;
  endtask

  task automatic send_resp(input logic [31:0] d, input logic fwd);
    ifetch_resp = mk_resp(d, 2'd1);
    if (fwd) exp_resp.push_back(ifetch_resp);
    tick();
    ifetch_resp = '0;
  endtask

  task automatic send_cmd(input logic h, input logic dr, input logic [31:0] d);
    debug_control = mk_cmd(h, dr, d);
    tick();
    debug_control = '0;
  endtask

  task automatic halt_now();
    send_cmd(1'b1, 1'b1, 32'd0);
    tick();
    @(negedge clk);
    chk("halt_reached", 64'(halted), 64'd1);
    tick();
  endtask

  task automatic inject_fetch(input logic [31:0] ins);
    t_riscv_fetch_resp e;
    send_cmd(1'b0, 1'b0, ins);
    tick();
    e = '0; e.valid = 1'b1; e.debug = 1'b1; e.mode = 3'h3; e.data = ins;
    exp_resp.push_back(e);
    pipeline_ifetch_req = mk_req(2'b10, 32'h0);
    @(negedge clk);
    chk("inject_req_blocked", 64'(ifetch_req.req_type), 64'd0);
    tick();
    pipeline_ifetch_req = '0;
  endtask

  task automatic retire(input logic trap, input logic rv, input logic [31:0] rd);
    pipeline_trace = '0;
    pipeline_trace.instr_valid = 1'b1;
    pipeline_trace.trap = trap;
    pipeline_trace.rfw_data_valid = rv;
    pipeline_trace.rfw_data = rd;
    pipeline_trace.instruction.debug.valid = 1'b1;
    tick();
    pipeline_trace = '0;
  endtask

  initial begin
    reset = 1'b1;
    debug_control = '0; pipeline_ifetch_req = '0; ifetch_resp = '0; pipeline_trace = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_dbg_rsp", 64'(debug_response), 64'd0);
    reset = 1'b0;
    tick();

    // Running passthrough
    pipeline_ifetch_req = mk_req(2'b01, 32'h100);
    @(negedge clk);
    chk("run_pass", 64'(ifetch_req), 64'(mk_req(2'b01, 32'h100)));
    tick();
    pipeline_ifetch_req = '0;
    send_resp(32'hAAAA_0001, 1'b1);

    // Halt with nothing outstanding (halt+dret together acts as halt)
    debug_control = mk_cmd(1'b1, 1'b1, 32'd0);
    tick();
    debug_control = '0;
    pipeline_ifetch_req = mk_req(2'b01, 32'h104);
    @(negedge clk);
    chk("drain_halted0", 64'(halted), 64'd0);
    chk("drain_block", 64'(ifetch_req.req_type), 64'd0);
    tick();
    pipeline_ifetch_req = '0;
    @(negedge clk);
    chk("halt_2cyc", 64'(halted), 64'd1);
    tick();

    // Halted: requests blocked, responses dropped, repeated halt ignored
    send_req(32'h108, 1'b0);
    send_resp(32'hDEAD_BEEF, 1'b0);
    send_cmd(1'b1, 1'b0, 32'd0);
    @(negedge clk);
    chk("halt_ignored", 64'(halted), 64'd1);
    tick();

    // Inject addi x1,x0,5 ; non-debug retire ignored ; retire rd=5
    inject_fetch(32'h0050_0093);
    @(negedge clk);
    chk("wait_halted", 64'(halted), 64'd1);
    tick();
    pipeline_trace.instr_valid = 1'b1;
    tick();
    pipeline_trace = '0;
    exp_dbg.push_back(mk_dbg(1'b0, 32'd5));
    retire(1'b0, 1'b1, 32'd5);
    tick();
    chk("inj1_seen", 64'(dbg_seen), 64'd1);

    // Inject with trap at retirement
    inject_fetch(32'h0000_0073);
    exp_dbg.push_back(mk_dbg(1'b1, 32'd0));
    retire(1'b1, 1'b0, 32'h1234);
    tick();
    @(negedge clk);
    chk("trap_halted", 64'(halted), 64'd1);
    chk("inj2_seen", 64'(dbg_seen), 64'd2);
    tick();

    // dret: one flush cycle, then plain passthrough
    send_cmd(1'b0, 1'b1, 32'd0);
    pipeline_ifetch_req = mk_req(2'b01, 32'h200);
    @(negedge clk);
    chk("resume_flush", 64'(ifetch_req), 64'({1'b1, 2'b01, 32'h200}));
    chk("resume_halted", 64'(halted), 64'd0);
    tick();
    @(negedge clk);
    chk("run_noflush", 64'(ifetch_req), 64'(mk_req(2'b01, 32'h200)));
    tick();
    pipeline_ifetch_req = '0;
    send_resp(32'h1111_0000, 1'b1);
    send_resp(32'h2222_0000, 1'b1);

    // Halt with 2 outstanding; responses 3 and 5 cycles after the command
    send_req(32'h300, 1'b1);
    send_req(32'h304, 1'b1);
    for (int i = 0; i <= 6; i++) begin
      if (i == 0) debug_control = mk_cmd(1'b1, 1'b0, 32'd0);
      if (i == 3 || i == 5) begin
        ifetch_resp = mk_resp(32'h3000_0000 + 32'(i), 2'd2);
        exp_resp.push_back(ifetch_resp);
      end
      @(negedge clk);
      chk($sformatf("drain2_c%0d", i), 64'(halted), (i == 6) ? 64'd1 : 64'd0);
      tick();
      debug_control = '0;
      ifetch_resp = '0;
    end

    // Reset mid-INJECT: abandon, back to running
    send_cmd(1'b0, 1'b0, 32'h1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    pipeline_ifetch_req = mk_req(2'b01, 32'h400);
    @(negedge clk);
    chk("rst_inj_halted", 64'(halted), 64'd0);
    chk("rst_inj_pass", 64'(ifetch_req.req_type), 64'd1);
    tick();
    pipeline_ifetch_req = '0;
    send_resp(32'h4000_0000, 1'b1);

    // Reset mid-WAIT_RETIRE coinciding with retirement: no pulse
    halt_now();
    inject_fetch(32'h0010_0113);
    reset = 1'b1;
    pipeline_trace.instr_valid = 1'b1;
    pipeline_trace.instruction.debug.valid = 1'b1;
    tick();
    reset = 1'b0;
    pipeline_trace = '0;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_wait_halted", 64'(halted), 64'd0);
    chk("rst_wait_nopulse", 64'(dbg_seen), 64'd2);
    tick();

`ifdef RISCV_DEBUG_FETCH_TIMEOUT_EN
    // Watchdog: inject and never fetch
    halt_now();
    send_cmd(1'b0, 1'b0, 32'h0050_0093);
    exp_dbg.push_back(mk_dbg(1'b1, 32'hFFFF_FFFF));
    begin
      int start;
      start = dbg_seen;
      for (int i = 0; i < 300 && dbg_seen == start; i++) tick();
      chk("tmo_fired", 64'(dbg_seen - start), 64'd1);
    end
    @(negedge clk);
    chk("tmo_halted", 64'(halted), 64'd1);
    tick();
`endif

    repeat (3) tick();
    chk("sb_dbg_empty", 64'(exp_dbg.size()), 64'd0);
    chk("sb_resp_empty", 64'(exp_resp.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
